// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Instruction-fetch controller for the single-issue core. Holds the program
// counter, drives the combinational instruction memory address, captures the
// returned word into a registered output slot and presents it to decode over
// a valid/ready handshake. Taken branches/jumps redirect the fetch stream.
//
// Parameters:
//   AW  instruction memory address width (word addressed)
//   DW  instruction width
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          begin fetching at start_addr (only in IDLE or HALT)
//   start_addr     first fetch address
//   imem_addr      address to instruction memory (the pc register)
//   imem_rdata     instruction memory read data, combinational from imem_addr
//   instr          registered instruction word
//   instr_pc       address the word in instr was fetched from
//   instr_valid    instr/instr_pc hold an unconsumed instruction
//   instr_ready    decode accepts instr this cycle
//   redirect       taken branch/jump (only honoured while fetching)
//   redirect_addr  new fetch address
//   busy           state is FETCH
//   halted         state is HALT
//
// Optional feature macro: FETCH_HALT_EN
//   When defined, an all-zero instruction word stops fetching (HALT state)
//   instead of being issued. When undefined, zero words are issued as NOPs
//   and fetch runs until reset, wrapping at the top of memory.

module fetch_sequencer #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;

    // The slot can take a new word when it is empty or its word is being
    // handed to decode on this same edge.
    logic slot_free;
    assign slot_free = !instr_valid || instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        pc          <= start_addr;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    // Redirect wins over capture: any pending word is
                    // dropped (a word handshaked this edge was consumed).
                    if (redirect) begin
                        pc          <= redirect_addr;
                        instr_valid <= 1'b0;
                    end else if (slot_free) begin
`ifdef FETCH_HALT_EN
                        if (imem_rdata == '0) begin
                            // Zero word is not captured; pc stays on it. The
                            // slot is free, so whatever it held is consumed.
                            instr_valid <= 1'b0;
                            state       <= HALT;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc + 1'b1;
                        end
`else
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 1'b1;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign busy      = (state == FETCH);
    assign halted    = (state == HALT);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the 256-word combinational instruction memory. It holds the program counter, drives the memory address, and captures the returned 32-bit word into a registered output slot. It hands the instruction to decode over a valid/ready handshake and accepts branch/jump redirects. It sits between the instruction memory and the decode stage of the single-issue core.

## Interface
- `AW`, 8, instruction memory address width (word addressed)
- `DW`, 32, instruction width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin fetching from `start_addr`; honoured only in IDLE or HALT
- `start_addr`  in  AW  first fetch address
- `imem_addr`  out  AW  address to instruction memory `A`; equals `pc` register
- `imem_rdata`  in  DW  instruction memory `RD`, combinational from `imem_addr`
- `instr`  out  DW  registered instruction word
- `instr_pc`  out  AW  address the word in `instr` was fetched from
- `instr_valid`  out  1  `instr` / `instr_pc` hold an unconsumed instruction
- `instr_ready`  in  1  decode accepts `instr` this cycle
- `redirect`  in  1  taken branch/jump; honoured only in FETCH
- `redirect_addr`  in  AW  new fetch address
- `busy`  out  1  state is FETCH
- `halted`  out  1  state is HALT

## Operation
- States: IDLE, FETCH, HALT. The state is registered. `busy` and `halted` decode the state combinationally.
- IDLE/HALT:
  - `start` = 1 → `pc` <= `start_addr`, `instr_valid` <= 0, state → FETCH.
  - `redirect` is ignored.
- FETCH, evaluated each edge in this priority order:
  1. `redirect` = 1:
     - `pc` <= `redirect_addr`, `instr_valid` <= 0.
     - A pending unconsumed word is dropped; a word handshaked this cycle counts as consumed.
  2. Slot free, i.e. `!instr_valid || instr_ready`:
     - `instr` <= `imem_rdata`, `instr_pc` <= `pc`, `instr_valid` <= 1.
     - `pc` <= `pc` + 1, modulo 2^AW (255 → 0).
  3. Otherwise (stall): `pc`, `instr`, `instr_pc` and `instr_valid` all hold.
- Handshake:
  - A transfer occurs on an edge with `instr_valid && instr_ready`.
  - Once asserted, `instr_valid` stays high and `instr` stays stable until the transfer or a redirect.
- `start` during FETCH is ignored.

## Timing
- Reset values: `pc` = 0, state = IDLE, `instr` = 0, `instr_pc` = 0, `instr_valid` = 0, `busy` = 0, `halted` = 0, `imem_addr` = 0.
- Reset is asynchronous. Assertion mid-fetch clears all state immediately, with no drain.
- `start` sampled at edge N → `imem_addr` = `start_addr` after N → first word valid after edge N+1.
- Throughput is one instruction per cycle with `instr_ready` held high.
- Redirect sampled at edge N:
  - `instr_valid` = 0 after N.
  - Target word valid after N+1 (one bubble).
- `imem_addr` changes only on clock edges (registered `pc`), so the memory output settles within the cycle.

## Configuration
- `FETCH_HALT_EN` defined:
  - In FETCH with the slot free and no redirect, a `imem_rdata` of 0x00000000 is not captured.
  - State → HALT, `pc` holds the zero-word address.
  - The slot keeps any pending valid word until consumed.
  - Redirect in the same cycle takes priority over halt.
- Undefined: there is no HALT entry. Zero words are issued as ordinary instructions (NOP), and fetch runs until reset, wrapping 255 → 0.

## Test plan
- Reset, `start` = 1 with `start_addr` = 0, `instr_ready` = 1 → consecutive transfers (`instr_pc`, `instr`):
  - (0, 0x20010003)
  - (1, 0x20020009)
  - (2, 0x00221020)
  - … through (6, program word 6)
  - `busy` = 1 throughout.
- `FETCH_HALT_EN`: continue past pc 6 → `halted` = 1 the cycle after pc 6 is captured; `imem_addr` = 7; `instr_valid` falls after pc 6 transfers; `start` = 1 with `start_addr` = 2 restarts at (2, 0x00221020).
- Without `FETCH_HALT_EN`: run 260 cycles, ready high → pc 7…255 yield `instr` = 0; `instr_pc` wraps 255 → 0, then (0, 0x20010003) reappears.
- Stall: drop `instr_ready` for 2 cycles while (2, 0x00221020) is presented → outputs stable, `imem_addr` = 3; ready high → next transfer is pc 3.
- Redirect: assert `redirect` with `redirect_addr` = 5 while pc 1 is presented and ready = 0 → next cycle `instr_valid` = 0, following cycle `instr_pc` = 5; pc 1 is never transferred.
- Async reset: pull `rst_n` low between edges during FETCH → `instr_valid`, `busy`, `imem_addr` go to 0 without waiting for `clk`; state is IDLE after release.
